// File: rtl/multicycle_ctrl.sv
// Multicycle MIPS-subset control FSM: sequences each instruction through
// fetch/decode/execute/memory/writeback and drives the shared datapath controls.
module multicycle_ctrl (
    input  logic       clk,
    input  logic       reset,
    input  logic [5:0] op,
    input  logic [5:0] funct,
    input  logic       zero,
    output logic       pcen,
    output logic       memwrite,
    output logic       irwrite,
    output logic       regwrite,
    output logic       iord,
    output logic       memtoreg,
    output logic       regdst,
    output logic       alusrca,
    output logic [1:0] alusrcb,
    output logic [1:0] pcsrc,
    output logic [2:0] alucontrol,
    output logic       illegal,
    output logic [3:0] state
);

    typedef enum logic [3:0] {
        StFetch   = 4'd0,
        StDecode  = 4'd1,
        StMemAdr  = 4'd2,
        StMemRd   = 4'd3,
        StMemWb   = 4'd4,
        StMemWr   = 4'd5,
        StRtypeEx = 4'd6,
        StRtypeWb = 4'd7,
        StBeqEx   = 4'd8,
        StAddiEx  = 4'd9,
        StAddiWb  = 4'd10,
        StJEx     = 4'd11,
        StBneEx   = 4'd12
    } state_e;

    localparam logic [5:0] OpRtype = 6'b000000;
    localparam logic [5:0] OpLw    = 6'b100011;
    localparam logic [5:0] OpSw    = 6'b101011;
    localparam logic [5:0] OpBeq   = 6'b000100;
    localparam logic [5:0] OpBne   = 6'b000101;
    localparam logic [5:0] OpAddi  = 6'b001000;
    localparam logic [5:0] OpJ     = 6'b000010;

    // Kept as a plain vector so unused encodings 13-15 stay representable.
    logic [3:0] state_q, state_d;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= StFetch;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d    = StFetch;
        pcen       = 1'b0;
        memwrite   = 1'b0;
        irwrite    = 1'b0;
        regwrite   = 1'b0;
        iord       = 1'b0;
        memtoreg   = 1'b0;
        regdst     = 1'b0;
        alusrca    = 1'b0;
        alusrcb    = 2'b00;
        pcsrc      = 2'b00;
        alucontrol = 3'b010;
        illegal    = 1'b0;

        case (state_q)
            StFetch: begin
                alusrcb = 2'b01;
                irwrite = 1'b1;
                pcen    = 1'b1;
                state_d = StDecode;
            end
            StDecode: begin
                alusrcb = 2'b11;
                case (op)
                    OpLw, OpSw: state_d = StMemAdr;
                    OpRtype:    state_d = StRtypeEx;
                    OpBeq:      state_d = StBeqEx;
                    OpBne:      state_d = StBneEx;
                    OpAddi:     state_d = StAddiEx;
                    OpJ:        state_d = StJEx;
                    default:    illegal = 1'b1;
                endcase
            end
            StMemAdr, StAddiEx: begin
                alusrca = 1'b1;
                alusrcb = 2'b10;
                if (state_q == StAddiEx) begin
                    state_d = StAddiWb;
                end else if (op == OpSw) begin
                    state_d = StMemWr;
                end else begin
                    state_d = StMemRd;
                end
            end
            StMemRd: begin
                iord    = 1'b1;
                state_d = StMemWb;
            end
            StMemWr: begin
                iord     = 1'b1;
                memwrite = 1'b1;
            end
            StMemWb: begin
                memtoreg = 1'b1;
                regwrite = 1'b1;
            end
            StRtypeEx: begin
                alusrca = 1'b1;
                state_d = StRtypeWb;
                case (funct)
                    6'b100000: alucontrol = 3'b010;
                    6'b100010: alucontrol = 3'b110;
                    6'b100100: alucontrol = 3'b000;
                    6'b100101: alucontrol = 3'b001;
                    6'b101010: alucontrol = 3'b111;
                    default: begin
                        illegal = 1'b1;
                        state_d = StFetch;
                    end
                endcase
            end
            StRtypeWb: begin
                regdst   = 1'b1;
                regwrite = 1'b1;
            end
            StAddiWb: begin
                regwrite = 1'b1;
            end
            StBeqEx, StBneEx: begin
                alusrca    = 1'b1;
                alucontrol = 3'b110;
                pcsrc      = 2'b01;
                pcen       = (state_q == StBeqEx) ? zero : ~zero;
            end
            StJEx: begin
                pcsrc = 2'b10;
                pcen  = 1'b1;
            end
            default: ;
        endcase

        // Reset aborts the instruction: no architectural write may happen this cycle.
        if (reset) begin
            pcen     = 1'b0;
            memwrite = 1'b0;
            irwrite  = 1'b0;
            regwrite = 1'b0;
            illegal  = 1'b0;
        end
    end

    assign state = state_q;

endmodule
